// File: rtl/i2s_rx_if.sv
// I2S receiver port bundle: serial pins in, parallel sample pairs out.
// frame_err exists only when I2S_RX_ERR_EN is defined.
interface i2s_rx_if #(
    parameter int DAT_WDTH = 24
);
    logic                sck;
    logic                ws;
    logic                sd;
    logic [DAT_WDTH-1:0] left_chan;
    logic [DAT_WDTH-1:0] right_chan;
    logic                valid;
`ifdef I2S_RX_ERR_EN
    logic                frame_err;

    modport slave  (input  sck, ws, sd, output left_chan, right_chan, valid, frame_err);
    modport master (output sck, ws, sd, input  left_chan, right_chan, valid, frame_err);
`else
    modport slave  (input  sck, ws, sd, output left_chan, right_chan, valid);
    modport master (output sck, ws, sd, input  left_chan, right_chan, valid);
`endif
endinterface

// File: rtl/i2s_rx.sv
// I2S deserialiser: synchronises sck/ws/sd into clk and emits left/right pairs with a valid pulse.
// Optional slot-length checking on frame_err is built when I2S_RX_ERR_EN is defined.
module i2s_rx #(
    parameter int DAT_WDTH  = 24,
    parameter int SLOT_WDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    i2s_rx_if.slave  bus
);
    localparam int CW = $clog2(SLOT_WDTH + 2);
`ifdef I2S_RX_ERR_EN
    // Count one past the nominal slot so an over-long slot is distinguishable.
    localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_WDTH + 1);
`else
    localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_WDTH);
`endif

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    logic [2:0]          sck_sync_reg;
    logic [1:0]          ws_sync_reg;
    logic [1:0]          sd_sync_reg;
    logic                ws_prev_reg;
    logic [DAT_WDTH-1:0] word_reg;
    logic [CW-1:0]       cnt_reg;
    logic [DAT_WDTH-1:0] hold_reg;
    logic [DAT_WDTH-1:0] left_reg;
    logic [DAT_WDTH-1:0] right_reg;
    logic                valid_reg;
    state_t              state_reg;
    state_t              state_next;
    logic                latch_left;
    logic                latch_pair;
    logic [DAT_WDTH-1:0] word_merged;
    logic [CW-1:0]       cnt_next;
    logic                rise;
    logic                ws_s;
    logic                sd_s;
    logic                ws_edge;

    assign rise    = sck_sync_reg[1] & ~sck_sync_reg[2];
    assign ws_s    = ws_sync_reg[1];
    assign sd_s    = sd_sync_reg[1];
    assign ws_edge = ws_s ^ ws_prev_reg;
    assign cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);

    // Bit gi takes sd only when the counter points at it; past DAT_WDTH nothing matches.
    generate
        for (genvar gi = 0; gi < DAT_WDTH; gi++) begin : g_merge
            assign word_merged[gi] = (cnt_reg == CW'(DAT_WDTH - 1 - gi)) ? sd_s : word_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_reg <= '0;
            ws_sync_reg  <= '0;
            sd_sync_reg  <= '0;
        end else begin
            sck_sync_reg <= {sck_sync_reg[1:0], bus.sck};
            ws_sync_reg  <= {ws_sync_reg[0], bus.ws};
            sd_sync_reg  <= {sd_sync_reg[0], bus.sd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        latch_left = 1'b0;
        latch_pair = 1'b0;
        if (rise && ws_edge) begin
            case (state_reg)
                SYNC: begin
                    if (!ws_s) state_next = LEFT;
                end
                LEFT: begin
                    if (ws_s) begin
                        latch_left = 1'b1;
                        state_next = RIGHT;
                    end
                end
                RIGHT: begin
                    if (!ws_s) begin
                        latch_pair = 1'b1;
                        state_next = LEFT;
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

    // The bit sampled on a ws edge closes the previous channel, so the finished word is word_merged.
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_prev_reg <= 1'b0;
            word_reg    <= '0;
            cnt_reg     <= '0;
            hold_reg    <= '0;
            left_reg    <= '0;
            right_reg   <= '0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= latch_pair;
            if (rise) begin
                ws_prev_reg <= ws_s;
                if (ws_edge) begin
                    word_reg <= '0;
                    cnt_reg  <= '0;
                end else begin
                    word_reg <= word_merged;
                    cnt_reg  <= cnt_next;
                end
            end
            if (latch_left) begin
                hold_reg <= word_merged;
            end
            if (latch_pair) begin
                right_reg <= word_merged;
                left_reg  <= hold_reg;
            end
        end
    end

    assign bus.left_chan  = left_reg;
    assign bus.right_chan = right_reg;
    assign bus.valid      = valid_reg;

`ifdef I2S_RX_ERR_EN
    logic err_reg;

    // Slot length is cnt+1 at the closing edge; compare against the nominal slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= rise && ws_edge && (state_reg != SYNC) &&
                       (cnt_reg != CW'(SLOT_WDTH - 1));
        end
    end

    assign bus.frame_err = err_reg;
`endif
endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: an I2S transmitter model at fclk/fsck = 4 feeds directed frames.
module tb_i2s_rx;
    localparam int DW = 24;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   exp_err;
    int   err_seen;
    logic [47:0] exp_q[$];

    i2s_rx_if #(.DAT_WDTH(DW)) bus ();

    i2s_rx #(.DAT_WDTH(DW), .SLOT_WDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One sck period: data and ws change on the falling edge, two clk per phase.
    task automatic send_bit(input logic ws_v, input logic sd_v);
        bus.sck = 1'b0;
        bus.ws  = ws_v;
        bus.sd  = sd_v;
        #20;
        bus.sck = 1'b1;
        #20;
    endtask

    // ws switches one bit early, so the channel LSB goes out with the next channel's ws.
    task automatic send_slot(input logic [31:0] d, input int slot, input logic ch,
                             input int first, input int last);
        for (int k = first; k <= last; k++) begin
            send_bit((k == slot - 1) ? ~ch : ch, d[5'(slot - 1 - k)]);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input int lslot,
                              input logic [31:0] r, input int rslot,
                              input bit synced, input logic [23:0] el, input logic [23:0] er);
        if (synced) begin
            exp_q.push_back({el, er});
            exp_err += int'(lslot != 32) + int'(rslot != 32);
        end
        send_slot(l, lslot, 1'b0, 0, lslot - 1);
        send_slot(r, rslot, 1'b1, 0, rslot - 1);
    endtask

    task automatic idle_sck();
        bus.sck = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_left"},  32'(bus.left_chan),  32'h0);
        chk({tag, "_right"}, 32'(bus.right_chan), 32'h0);
        chk({tag, "_valid"}, 32'(bus.valid),      32'h0);
    endtask

    // Monitor: every valid pops one expected pair.
    always @(negedge clk) begin
        if (bus.valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got left=%h right=%h expected no valid",
                         bus.left_chan, bus.right_chan);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                chk("pair_left",  32'(bus.left_chan),  32'(e[47:24]));
                chk("pair_right", 32'(bus.right_chan), 32'(e[23:0]));
                $display("[TB] pair left=%h right=%h (exp %h %h)",
                         bus.left_chan, bus.right_chan, e[47:24], e[23:0]);
            end
        end
`ifdef I2S_RX_ERR_EN
        if (bus.frame_err) err_seen++;
`endif
    end

    initial begin
        tests    = 0;
        fails    = 0;
        exp_err  = 0;
        err_seen = 0;
        rst      = 1'b1;
        bus.sck  = 1'b0;
        bus.ws   = 1'b0;
        bus.sd   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // Nominal: first frame only syncs, following frames deliver; excess slot bits are junk.
        send_frame({24'hABCDEF, 8'h5C}, 32, {24'h123456, 8'hA3}, 32, 1'b0, 24'h0, 24'h0);
        send_frame({24'hABCDEF, 8'h5C}, 32, {24'h123456, 8'hA3}, 32, 1'b1, 24'hABCDEF, 24'h123456);
        send_frame({24'hABCDEF, 8'hFF}, 32, {24'h123456, 8'hFF}, 32, 1'b1, 24'hABCDEF, 24'h123456);

        // Short 16-bit slots: left-aligned with zero LSBs.
        send_frame(32'h0000A5A5, 16, 32'h00005A5A, 16, 1'b1, 24'hA5A500, 24'h5A5A00);

        // Edge-bit ownership with 24-bit slots.
        send_frame(32'h00000001, 24, 32'h007FFFFF, 24, 1'b1, 24'h000001, 24'h7FFFFF);

`ifdef I2S_RX_ERR_EN
        send_frame({24'hABCDEF, 7'h00}, 31, {24'h123456, 8'h00}, 32, 1'b1, 24'hABCDEF, 24'h123456);
`endif
        send_frame({24'h0F1E2D, 8'h00}, 32, {24'hC3B2A1, 8'h00}, 32, 1'b1, 24'h0F1E2D, 24'hC3B2A1);
        idle_sck();
        chk("hold_left",  32'(bus.left_chan),  32'h0F1E2D);
        chk("hold_right", 32'(bus.right_chan), 32'hC3B2A1);

        // Reset released with ws high mid-right-slot: the tail only syncs.
        bus.ws = 1'b1;
        do_reset();
        chk_zero("rst_ws_high");
        send_slot(32'h0, 11, 1'b1, 0, 10);
        send_frame({24'h13579B, 8'h00}, 32, {24'h2468AC, 8'h00}, 32, 1'b1, 24'h13579B, 24'h2468AC);
        idle_sck();

        // Reset mid-left-slot: the interrupted frame is dropped.
        send_slot({24'hDEAD01, 8'h00}, 32, 1'b0, 0, 9);
        idle_sck();
        do_reset();
        chk_zero("rst_mid");
        send_slot({24'hDEAD01, 8'h00}, 32, 1'b0, 10, 31);
        send_slot({24'hBEEF02, 8'h00}, 32, 1'b1, 0, 31);
        send_frame({24'hABCDEF, 8'h00}, 32, {24'h123456, 8'h00}, 32, 1'b1, 24'hABCDEF, 24'h123456);
        idle_sck();
        repeat (10) @(negedge clk);

        chk("pending_pairs", 32'(exp_q.size()), 32'h0);
`ifdef I2S_RX_ERR_EN
        chk("frame_err_count", 32'(err_seen), 32'(exp_err));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
